// File: rtl/mem_arb_pkg.sv
// Shared encodings and default parameters for the CPU/DMA memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } arb_owner_t;

    localparam int DEF_MAX_WAIT = 4;
    localparam int DEF_TIMEOUT  = 15;

endpackage

// File: rtl/mem_arb_timeout.sv
// Counts BUSY cycles without mem_ready; flags the cycle whose edge reaches TIMEOUT.
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic tick,
    input  logic ready,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_C = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FULL_C = CW'(TIMEOUT);

    logic [CW-1:0] cnt_r;

    // Wait-cycle counter, cleared when a transaction enters BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (start) begin
            cnt_r <= '0;
        end else if (tick && !ready && (cnt_r != FULL_C)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // mem_ready takes precedence, so a coinciding ready never reports expiry.
    assign expired = tick && !ready && (cnt_r == LAST_C);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter onto a single memory port, with DMA starvation
// protection and a BUSY timeout that completes the transaction with an error.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        dma_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] MAX_WAIT_C = SW'(MAX_WAIT);

    arb_state_t    state_r;
    arb_owner_t    owner_r;
    logic [SW-1:0] starve_cnt_r;
    logic          cpu_win_s;
    logic          dma_win_s;
    logic          start_s;
    logic          tick_s;
    logic          expired_s;

    function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] c);
        return (c == MAX_WAIT_C) ? c : c + SW'(1);
    endfunction

    // Arbitration: a waiting DMA forces its turn once starve_cnt hits MAX_WAIT;
    // with no DMA request the CPU is never blocked by a stale count.
    always_comb begin
        cpu_win_s = 1'b0;
        dma_win_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (cpu_req && ((starve_cnt_r < MAX_WAIT_C) || !dma_req)) begin
                cpu_win_s = 1'b1;
            end else if (dma_req) begin
                dma_win_s = 1'b1;
            end else begin
                cpu_win_s = 1'b0;
                dma_win_s = 1'b0;
            end
        end else begin
            cpu_win_s = 1'b0;
            dma_win_s = 1'b0;
        end
    end

    assign start_s = cpu_win_s | dma_win_s;
    assign tick_s  = (state_r == ST_BUSY);

    mem_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_s),
        .tick    (tick_s),
        .ready   (mem_ready),
        .expired (expired_s)
    );

    // Arbiter FSM with all memory-side and requester-side outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_CPU;
            starve_cnt_r <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'h0000_0000;
            mem_wdata    <= 32'h0000_0000;
            cpu_rdata    <= 32'h0000_0000;
            cpu_ack      <= 1'b0;
            cpu_err      <= 1'b0;
            dma_rdata    <= 32'h0000_0000;
            dma_ack      <= 1'b0;
            dma_err      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cpu_win_s) begin
                        owner_r      <= OWN_CPU;
                        mem_req      <= 1'b1;
                        mem_we       <= cpu_we;
                        mem_addr     <= cpu_addr;
                        mem_wdata    <= cpu_wdata;
                        starve_cnt_r <= dma_req ? starve_inc(starve_cnt_r) : '0;
                        state_r      <= ST_BUSY;
                    end else if (dma_win_s) begin
                        owner_r      <= OWN_DMA;
                        mem_req      <= 1'b1;
                        mem_we       <= dma_we;
                        mem_addr     <= dma_addr;
                        mem_wdata    <= dma_wdata;
                        starve_cnt_r <= '0;
                        state_r      <= ST_BUSY;
                    end else begin
                        starve_cnt_r <= '0;
                        state_r      <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state_r <= ST_RESP;
                        if (owner_r == OWN_CPU) begin
                            cpu_ack <= 1'b1;
                            cpu_err <= 1'b0;
                            if (!mem_we) begin
                                cpu_rdata <= mem_rdata;
                            end
                        end else begin
                            dma_ack <= 1'b1;
                            dma_err <= 1'b0;
                            if (!mem_we) begin
                                dma_rdata <= mem_rdata;
                            end
                        end
                    end else if (expired_s) begin
                        mem_req <= 1'b0;
                        state_r <= ST_RESP;
                        if (owner_r == OWN_CPU) begin
                            cpu_ack <= 1'b1;
                            cpu_err <= 1'b1;
                        end else begin
                            dma_ack <= 1'b1;
                            dma_err <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_RESP: begin
                    cpu_ack <= 1'b0;
                    cpu_err <= 1'b0;
                    dma_ack <= 1'b0;
                    dma_err <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    cpu_ack <= 1'b0;
                    cpu_err <= 1'b0;
                    dma_ack <= 1'b0;
                    dma_err <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus corner-case sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we, mem_ready;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_ack, cpu_err, dma_ack, dma_err, mem_req, mem_we;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic [31:0] mrd;
        logic        mrdy;
        logic        e_mreq, e_mwe;
        logic [31:0] e_maddr, e_mwdata;
        logic        e_cack, e_cerr, e_dack, e_derr;
        logic [31:0] e_crd, e_drd;
    } vec_t;

    vec_t vecs[16];

    mem_arbiter #(.MAX_WAIT(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_req"},   32'(mem_req),   32'h0);
        check({tag, "_mem_we"},    32'(mem_we),    32'h0);
        check({tag, "_mem_addr"},  mem_addr,       32'h0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'h0);
        check({tag, "_cpu_rdata"}, cpu_rdata,      32'h0);
        check({tag, "_cpu_ack"},   32'(cpu_ack),   32'h0);
        check({tag, "_cpu_err"},   32'(cpu_err),   32'h0);
        check({tag, "_dma_rdata"}, dma_rdata,      32'h0);
        check({tag, "_dma_ack"},   32'(dma_ack),   32'h0);
        check({tag, "_dma_err"},   32'(dma_err),   32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [31:0] addr);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr; cpu_wdata = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_crd;
        logic [31:0] exp_drd;
        logic        got_dma;
        logic        exp_dma;
        int          cyc;

        //        cr   cw   ca          cd            dr   dw   da          dd            mrd           mrdy  mreq mwe  maddr       mwdata        cack cerr dack derr crd           drd
        vecs[0]  = '{1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0, 1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'h0,32'h0};
        vecs[1]  = '{1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'hDEADBEEF,1'b1, 1'b0,1'b0,32'h100,32'h0, 1'b1,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
        vecs[2]  = '{1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0, 1'b0,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
        vecs[3]  = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0, 1'b0,1'b0,32'h100,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
        vecs[4]  = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h200,32'h12345678, 32'h0,1'b0, 1'b1,1'b1,32'h200,32'h12345678, 1'b0,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
        for (int i = 5; i < 9; i++) vecs[i] = vecs[4];
        vecs[9]  = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h200,32'h12345678, 32'hAAAA5555,1'b1, 1'b0,1'b1,32'h200,32'h12345678, 1'b0,1'b0,1'b1,1'b0, 32'hDEADBEEF,32'h0};
        vecs[10] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h200,32'h12345678, 32'h0,1'b0, 1'b0,1'b1,32'h200,32'h12345678, 1'b0,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
        vecs[11] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0, 1'b0,1'b1,32'h200,32'h12345678, 1'b0,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
        vecs[12] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h300,32'h0, 32'h0,1'b0, 1'b1,1'b0,32'h300,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'h0};
        vecs[13] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h300,32'h0, 32'hCAFEF00D,1'b1, 1'b0,1'b0,32'h300,32'h0, 1'b0,1'b0,1'b1,1'b0, 32'hDEADBEEF,32'hCAFEF00D};
        vecs[14] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h300,32'h0, 32'h0,1'b0, 1'b0,1'b0,32'h300,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'hCAFEF00D};
        vecs[15] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 32'h0,1'b0, 1'b0,1'b0,32'h300,32'h0, 1'b0,1'b0,1'b0,1'b0, 32'hDEADBEEF,32'hCAFEF00D};

        rst_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
        mem_rdata = 32'h0; mem_ready = 1'b0;
        #12;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Per-cycle table: CPU read, DMA write with 5 BUSY cycles, DMA read.
        for (int i = 0; i < 16; i++) begin
            cpu_req = vecs[i].cr; cpu_we = vecs[i].cw; cpu_addr = vecs[i].ca; cpu_wdata = vecs[i].cd;
            dma_req = vecs[i].dr; dma_we = vecs[i].dw; dma_addr = vecs[i].da; dma_wdata = vecs[i].dd;
            mem_rdata = vecs[i].mrd; mem_ready = vecs[i].mrdy;
            step();
            check($sformatf("v%0d_mem_req", i),   32'(mem_req),  32'(vecs[i].e_mreq));
            check($sformatf("v%0d_mem_we", i),    32'(mem_we),   32'(vecs[i].e_mwe));
            check($sformatf("v%0d_mem_addr", i),  mem_addr,      vecs[i].e_maddr);
            check($sformatf("v%0d_mem_wdata", i), mem_wdata,     vecs[i].e_mwdata);
            check($sformatf("v%0d_cpu_ack", i),   32'(cpu_ack),  32'(vecs[i].e_cack));
            check($sformatf("v%0d_cpu_err", i),   32'(cpu_err),  32'(vecs[i].e_cerr));
            check($sformatf("v%0d_dma_ack", i),   32'(dma_ack),  32'(vecs[i].e_dack));
            check($sformatf("v%0d_dma_err", i),   32'(dma_err),  32'(vecs[i].e_derr));
            check($sformatf("v%0d_cpu_rdata", i), cpu_rdata,     vecs[i].e_crd);
            check($sformatf("v%0d_dma_rdata", i), dma_rdata,     vecs[i].e_drd);
        end
        exp_crd = 32'hDEADBEEF;
        exp_drd = 32'hCAFEF00D;

        // Starvation: both requesting, expected grant order C,C,C,C,D then C.
        cpu_read(32'h10);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20; dma_wdata = 32'h0;
        for (int g = 0; g < 6; g++) begin
            exp_dma = (g == 4);
            cyc = 0;
            while (mem_req !== 1'b1 && cyc < 10) begin
                step();
                cyc++;
            end
            check($sformatf("g%0d_grant_seen", g), 32'(mem_req), 32'h1);
            got_dma = (mem_addr == 32'h20);
            check($sformatf("g%0d_grant_owner_is_dma", g), 32'(got_dma), 32'(exp_dma));
            if (got_dma) check("starve_cnt_after_dma", 32'(dut.starve_cnt_r), 32'h0);
            mem_ready = 1'b1;
            mem_rdata = 32'h5000_0000 | 32'(g);
            step();
            mem_ready = 1'b0;
            if (got_dma) exp_drd = 32'h5000_0000 | 32'(g);
            else         exp_crd = 32'h5000_0000 | 32'(g);
            check($sformatf("g%0d_winner_ack", g), 32'(got_dma ? dma_ack : cpu_ack), 32'h1);
            check($sformatf("g%0d_loser_ack", g),  32'(got_dma ? cpu_ack : dma_ack), 32'h0);
            check($sformatf("g%0d_cpu_rdata", g), cpu_rdata, exp_crd);
            check($sformatf("g%0d_dma_rdata", g), dma_rdata, exp_drd);
            step();
            if (got_dma) dma_req = 1'b0;
        end
        cpu_req = 1'b0;
        step();

        // Timeout: no mem_ready for 15 BUSY cycles.
        cpu_read(32'h400);
        mem_rdata = 32'hBAD0BAD0;
        step();
        check("to_enter_busy", 32'(mem_req), 32'h1);
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k < 15) check($sformatf("to_wait%0d_ack", k), 32'(cpu_ack), 32'h0);
            if (k < 15) check($sformatf("to_wait%0d_mem_req", k), 32'(mem_req), 32'h1);
        end
        check("to_cpu_ack", 32'(cpu_ack), 32'h1);
        check("to_cpu_err", 32'(cpu_err), 32'h1);
        check("to_mem_req", 32'(mem_req), 32'h0);
        check("to_cpu_rdata", cpu_rdata, exp_crd);
        check("to_dma_ack", 32'(dma_ack), 32'h0);
        cpu_req = 1'b0;
        step();
        check("to_ack_one_cycle", 32'(cpu_ack), 32'h0);
        check("to_err_clear", 32'(cpu_err), 32'h0);
        check("to_mem_req_after", 32'(mem_req), 32'h0);

        // mem_ready on the exact timeout cycle: normal completion.
        cpu_read(32'h500);
        mem_rdata = 32'h0F0F0F0F;
        step();
        for (int k = 1; k <= 15; k++) begin
            mem_ready = (k == 15);
            step();
        end
        mem_ready = 1'b0;
        exp_crd = 32'h0F0F0F0F;
        check("tie_cpu_ack", 32'(cpu_ack), 32'h1);
        check("tie_cpu_err", 32'(cpu_err), 32'h0);
        check("tie_cpu_rdata", cpu_rdata, exp_crd);
        check("tie_mem_req", 32'(mem_req), 32'h0);
        cpu_req = 1'b0;
        step();

        // Reset pulsed mid-BUSY, then a fresh CPU read.
        cpu_read(32'h600);
        step();
        step();
        check("rb_busy_mem_req", 32'(mem_req), 32'h1);
        mem_ready = 1'b1;
        mem_rdata = 32'h66666666;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rb_async");
        cpu_req = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("rb_no_ack%0d", k), 32'(cpu_ack), 32'h0);
            check($sformatf("rb_no_req%0d", k), 32'(mem_req), 32'h0);
        end
        mem_ready = 1'b0;
        cpu_read(32'h700);
        step();
        check("rb_new_mem_req", 32'(mem_req), 32'h1);
        check("rb_new_mem_addr", mem_addr, 32'h700);
        mem_ready = 1'b1;
        mem_rdata = 32'h77777777;
        step();
        mem_ready = 1'b0;
        check("rb_new_ack", 32'(cpu_ack), 32'h1);
        check("rb_new_err", 32'(cpu_err), 32'h0);
        check("rb_new_rdata", cpu_rdata, 32'h77777777);
        step();
        cpu_req = 1'b0;
        check("rb_new_ack_drop", 32'(cpu_ack), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
